// File: rtl/truth_table_checker.sv
// Truth-table sweep checker: drives every N_IN-bit vector to a combinational DUT,
// samples its 1-bit response after SETTLE cycles and scores it against EXPECTED.
module truth_table_checker #(
  parameter int                  N_IN     = 3,
  parameter logic [2**N_IN-1:0]  EXPECTED = 8'h67,
  parameter int                  SETTLE   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            resp,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            fail_seen,
  output logic [N_IN-1:0] first_fail,
  output logic            mismatch
);

  localparam int              CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC    = '1;

  // Handshake: start is a level sampled on rising edges; it is only accepted in
  // IDLE or DONE, and ignored while busy. Results are valid while done is high.
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t          state, stateNext;
  logic [CW-1:0]   settleCnt, settleCntNext;
  logic [N_IN-1:0] vecNext, firstFailNext;
  logic [N_IN:0]   errNext;
  logic            busyNext, doneNext, passNext, failSeenNext, mismatchNext;
  logic            expBit, sampleBad;

  assign expBit    = EXPECTED[vec];
  assign sampleBad = (state == SAMPLE) && (resp != expBit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settleCnt  <= '0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_seen  <= 1'b0;
      first_fail <= '0;
      mismatch   <= 1'b0;
    end else begin
      state      <= stateNext;
      settleCnt  <= settleCntNext;
      vec        <= vecNext;
      busy       <= busyNext;
      done       <= doneNext;
      pass       <= passNext;
      err_cnt    <= errNext;
      fail_seen  <= failSeenNext;
      first_fail <= firstFailNext;
      mismatch   <= mismatchNext;
    end
  end

  always_comb begin
    stateNext     = state;
    settleCntNext = settleCnt;
    vecNext       = vec;
    busyNext      = busy;
    doneNext      = done;
    passNext      = pass;
    errNext       = err_cnt;
    failSeenNext  = fail_seen;
    firstFailNext = first_fail;
    mismatchNext  = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          stateNext     = APPLY;
          settleCntNext = SETTLE_LOAD;
          vecNext       = '0;
          errNext       = '0;
          failSeenNext  = 1'b0;
          firstFailNext = '0;
          busyNext      = 1'b1;
          doneNext      = 1'b0;
          passNext      = 1'b0;
        end
      end
      APPLY: begin
        if (settleCnt == '0) stateNext = SAMPLE;
        else                 settleCntNext = settleCnt - 1'b1;
      end
      SAMPLE: begin
        if (sampleBad) begin
          errNext      = err_cnt + 1'b1;
          mismatchNext = 1'b1;
          failSeenNext = 1'b1;
          if (!fail_seen) firstFailNext = vec;
        end
        // vec only moves here, so the DUT sees each vector for SETTLE+1 cycles.
        if (vec != LAST_VEC) begin
          vecNext       = vec + 1'b1;
          stateNext     = APPLY;
          settleCntNext = SETTLE_LOAD;
        end else begin
          stateNext = DONE;
          busyNext  = 1'b0;
          doneNext  = 1'b1;
          passNext  = (errNext == '0);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule
